neurosync: RTL and testbench
============================

NEUROSYNC -- requirements
Module: neurosync

Interface
REQ-001 clock  in  1  system clock; 1 kHz nominal; all state changes on the rising edge.
REQ-002 reset  in  1  asynchronous, active-low reset; forces IDLE and clears all registers.
REQ-003 jogar  in  1  start request; level-sensitive, acted on in IDLE or in any end state.
REQ-004 nivel  in  1  difficulty select; sampled in CONFIG when confirma is accepted.
REQ-005 confirma  in  1  level confirmation; level-sensitive, acted on in CONFIG only.
REQ-006 botoes  in  4  player buttons; one-hot press, 4'b0000 = released.
REQ-007 leds  out  4  shows the pattern symbol during SHOW and echoes botoes during WAIT; 0 otherwise.
REQ-008 pronto  out  1  high in the WIN, LOSE and TOUT end states.
REQ-009 timeout  out  1  high in TOUT only.
REQ-010 HEX0..HEX5  out  7 each  active-low 7-segment patterns, bit0=a .. bit6=g.
REQ-011 Parameter T_SYM (default 100): cycles each symbol is lit during SHOW.
REQ-012 Parameter T_GAP (default 50): dark cycles after each symbol.
REQ-013 Parameter T_OUT0 (default 3000): per-play timeout in cycles when nivel=0.
REQ-014 Parameter T_OUT1 (default 1500): per-play timeout in cycles when nivel=1.

Function
REQ-015 States: IDLE, CONFIG, SHOW, WAIT, CHECK, NEXT, WIN, LOSE, TOUT.
REQ-016 IDLE: when jogar=1, go to CONFIG; clear round to 1 and the play index to 0.
REQ-017 CONFIG: when confirma=1, latch nivel into lvl and go to SHOW for round 1.
REQ-018 The game has 16 rounds; each round is a pair of symbols (s0, s1) taken from a fixed ROM.
REQ-019 ROM rounds 1-16: (0001,1000) (0100,0010) (0100,0001) (0100,1000) (0001,0100) (0100,0010) (1000,0001) (0001,1000) (0100,0010) (0010,0100) (0001,0100) (0100,0001) (1000,0100) (0100,1000) (1000,0001) (0001,0100).
REQ-020 SHOW: leds=s0 for T_SYM cycles, then 0 for T_GAP cycles, then s1 for T_SYM cycles, then 0 for T_GAP cycles; then go to WAIT with the play index at 0.
REQ-021 WAIT: the timeout counter runs from 0 each time WAIT is entered.
REQ-022 WAIT: reaching T_OUT0 or T_OUT1 (selected by lvl) with no accepted press goes to TOUT.
REQ-023 Press detection: a press is accepted on the cycle botoes changes from 0 to nonzero (rising edge of the OR of the bits); holding a button counts as one press.
REQ-024 A press whose value equals the last accepted press of the current round is ignored (no state change, timer keeps running); the ROM never has s0=s1.
REQ-025 An accepted press is registered and compared in CHECK one cycle later.
REQ-026 CHECK: a press that does not match the expected symbol (including a multi-hot value) goes to LOSE.
REQ-027 CHECK: a match at play index 0 sets the index to 1 and returns to WAIT.
REQ-028 CHECK: a match at play index 1 goes to NEXT.
REQ-029 NEXT: if round=16 go to WIN; otherwise increment round, clear the last-press memory and go to SHOW.
REQ-030 WIN, LOSE and TOUT hold until jogar=1, which goes to CONFIG with round=1; confirma is ignored there.
REQ-031 Display digits:
- HEX1:HEX0 = round in decimal (01..16; 00 in IDLE).
- HEX2 = lvl (0/1).
- HEX3 = play index.
- HEX4 = state code: IDLE0 CONFIG1 SHOW2 WAIT3 CHECK4 NEXT5 WIN6 LOSE7 TOUT8.
- HEX5 = blank (7'h7F).
REQ-032 jogar is ignored in every state except IDLE and the end states.

Reset
REQ-033 While reset=0, and one cycle after release:
- state=IDLE, round=0, lvl=0, all counters 0.
- leds=0, pronto=0, timeout=0.
- HEX0-HEX2 show 0, HEX4 shows 0, HEX5 blank.
REQ-034 A reset asserted in any state aborts the game immediately, with no completion of the current action.

Verification
REQ-035 Reset, then jogar=1 for 5 cycles -> state CONFIG, HEX4=1, pronto=0; confirma=1 with nivel=0 -> SHOW, leds=0001 for 100 cycles, 0 for 50, then 1000 for 100.
REQ-036 Round 1: press 0001 for 10 cycles, 0001 again, then 1000 -> the second 0001 is ignored, round advances to 2, HEX1:HEX0=02, SHOW displays 0100 then 0010.
REQ-037 Play all 16 rounds correctly per the REQ-019 ROM -> state WIN, pronto=1, timeout=0, HEX1:HEX0=16.
REQ-038 In round 2, press 0001 -> LOSE, pronto=1, timeout=0.
REQ-039 With nivel=1 confirmed and no press -> TOUT exactly 1500 cycles after WAIT entry, pronto=1, timeout=1; then jogar=1 -> CONFIG, pronto=0.
REQ-040 Assert reset=0 mid-SHOW -> leds=0 and state IDLE with no clock edge required.

Source files
------------

// File: rtl/neurosync.sv
// neurosync: two-symbol-per-round memory game; SHOW plays the round pattern, WAIT times the player's presses.
// Button presses are rising-edge detected on the OR of botoes; HEX digits show round, level, play index and state.
module neurosync #(
  parameter int T_SYM  = 100,
  parameter int T_GAP  = 50,
  parameter int T_OUT0 = 3000,
  parameter int T_OUT1 = 1500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       nivel,
  input  logic       confirma,
  input  logic [3:0] botoes,
  output logic [3:0] leds,
  output logic       pronto,
  output logic       timeout,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  // State encoding doubles as the HEX4 state code.
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_CONFIG = 4'd1;
  localparam logic [3:0] S_SHOW   = 4'd2;
  localparam logic [3:0] S_WAIT   = 4'd3;
  localparam logic [3:0] S_CHECK  = 4'd4;
  localparam logic [3:0] S_NEXT   = 4'd5;
  localparam logic [3:0] S_WIN    = 4'd6;
  localparam logic [3:0] S_LOSE   = 4'd7;
  localparam logic [3:0] S_TOUT   = 4'd8;

  localparam logic [15:0] SYM_L  = 16'(T_SYM - 1);
  localparam logic [15:0] GAP_L  = 16'(T_GAP - 1);
  localparam logic [15:0] OUT0_L = 16'(T_OUT0 - 1);
  localparam logic [15:0] OUT1_L = 16'(T_OUT1 - 1);

  logic [3:0]  state;
  logic [4:0]  round;
  logic        idx;
  logic        lvl;
  logic [1:0]  phase;
  logic [15:0] cnt;
  logic [3:0]  last;
  logic [3:0]  pres;
  logic        prev_any;
  logic        press;
  logic [7:0]  pair;
  logic [3:0]  expected;
  logic [4:0]  ones;

  function automatic logic [7:0] rom(input logic [4:0] r);
    case (r)
      5'd1:    rom = 8'h18;
      5'd2:    rom = 8'h42;
      5'd3:    rom = 8'h41;
      5'd4:    rom = 8'h48;
      5'd5:    rom = 8'h14;
      5'd6:    rom = 8'h42;
      5'd7:    rom = 8'h81;
      5'd8:    rom = 8'h18;
      5'd9:    rom = 8'h42;
      5'd10:   rom = 8'h24;
      5'd11:   rom = 8'h14;
      5'd12:   rom = 8'h41;
      5'd13:   rom = 8'h84;
      5'd14:   rom = 8'h48;
      5'd15:   rom = 8'h81;
      5'd16:   rom = 8'h14;
      default: rom = 8'h00;
    endcase
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
  endfunction

  assign pair     = rom(round);
  assign expected = idx ? pair[3:0] : pair[7:4];
  assign press    = (|botoes) & ~prev_any;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      round    <= '0;
      idx      <= 1'b0;
      lvl      <= 1'b0;
      phase    <= '0;
      cnt      <= '0;
      last     <= '0;
      pres     <= '0;
      prev_any <= 1'b0;
    end else begin
      prev_any <= |botoes;
      case (state)
        S_IDLE: if (jogar) begin
          state <= S_CONFIG;
          round <= 5'd1;
          idx   <= 1'b0;
        end
        S_CONFIG: if (confirma) begin
          lvl   <= nivel;
          state <= S_SHOW;
          phase <= '0;
          cnt   <= '0;
          last  <= '0;
        end
        // Phases 0/2 light a symbol, 1/3 are the dark gaps after each.
        S_SHOW: if (cnt == (phase[0] ? GAP_L : SYM_L)) begin
          cnt   <= '0;
          phase <= phase + 2'd1;
          if (phase == 2'd3) begin
            state <= S_WAIT;
            idx   <= 1'b0;
          end
        end else begin
          cnt <= cnt + 16'd1;
        end
        // A repeat of the last accepted value is ignored and the timer keeps running.
        S_WAIT: if (press && botoes != last) begin
          pres  <= botoes;
          last  <= botoes;
          state <= S_CHECK;
        end else if (cnt == (lvl ? OUT1_L : OUT0_L)) begin
          state <= S_TOUT;
        end else begin
          cnt <= cnt + 16'd1;
        end
        S_CHECK: if (pres != expected) begin
          state <= S_LOSE;
        end else if (!idx) begin
          idx   <= 1'b1;
          cnt   <= '0;
          state <= S_WAIT;
        end else begin
          state <= S_NEXT;
        end
        S_NEXT: if (round == 5'd16) begin
          state <= S_WIN;
        end else begin
          round <= round + 5'd1;
          last  <= '0;
          cnt   <= '0;
          phase <= '0;
          state <= S_SHOW;
        end
        S_WIN, S_LOSE, S_TOUT: if (jogar) begin
          state <= S_CONFIG;
          round <= 5'd1;
          idx   <= 1'b0;
          cnt   <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    leds = '0;
    if (state == S_SHOW) begin
      if (phase == 2'd0) leds = pair[7:4];
      else if (phase == 2'd2) leds = pair[3:0];
    end else if (state == S_WAIT) begin
      leds = botoes;
    end
  end

  assign pronto  = (state == S_WIN) || (state == S_LOSE) || (state == S_TOUT);
  assign timeout = (state == S_TOUT);

  assign ones = (round >= 5'd10) ? round - 5'd10 : round;
  assign HEX0 = seg(ones[3:0]);
  assign HEX1 = seg({3'b000, round >= 5'd10});
  assign HEX2 = seg({3'b000, lvl});
  assign HEX3 = seg({3'b000, idx});
  assign HEX4 = seg(state);
  assign HEX5 = 7'h7F;

endmodule

// File: tb/tb_neurosync.sv
// Directed game scenarios with randomized press timing, checked against a round/index/last-press game model.
module tb_neurosync;
  localparam int T_SYM = 100;
  localparam int T_GAP = 50;

  logic       clock, reset, jogar, nivel, confirma;
  logic [3:0] botoes, leds;
  logic       pronto, timeout;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  int checks, failures;
  int m_round;
  bit m_idx;
  bit m_lvl;
  logic [3:0] m_last;
  logic [3:0] rom_s0 [1:16];
  logic [3:0] rom_s1 [1:16];

  neurosync dut (
    .clock(clock), .reset(reset), .jogar(jogar), .nivel(nivel), .confirma(confirma),
    .botoes(botoes), .leds(leds), .pronto(pronto), .timeout(timeout),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: seg = 7'b1000000;
      1: seg = 7'b1111001;
      2: seg = 7'b0100100;
      3: seg = 7'b0110000;
      4: seg = 7'b0011001;
      5: seg = 7'b0010010;
      6: seg = 7'b0000010;
      7: seg = 7'b1111000;
      8: seg = 7'b0000000;
      9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_checks();
    chk("idle_state", {25'd0, HEX4}, {25'd0, seg(0)});
    chk("idle_hex0", {25'd0, HEX0}, {25'd0, seg(0)});
    chk("idle_hex1", {25'd0, HEX1}, {25'd0, seg(0)});
    chk("idle_hex2", {25'd0, HEX2}, {25'd0, seg(0)});
    chk("idle_hex5", {25'd0, HEX5}, 32'h7F);
    chk("idle_leds", {28'd0, leds}, 32'd0);
    chk("idle_pronto", {31'd0, pronto}, 32'd0);
    chk("idle_timeout", {31'd0, timeout}, 32'd0);
  endtask

  // Called just after the clock edge that entered SHOW.
  task automatic show_check(input int r);
    int bad;
    logic [3:0] e;
    bad = -1;
    chk("show_state", {25'd0, HEX4}, {25'd0, seg(2)});
    chk("show_round", {18'd0, HEX1, HEX0}, {18'd0, seg(r / 10), seg(r % 10)});
    chk("show_lvl", {25'd0, HEX2}, {25'd0, seg(int'(m_lvl))});
    for (int t = 0; t < 2 * (T_SYM + T_GAP); t++) begin
      if (t < T_SYM) e = rom_s0[r];
      else if (t < T_SYM + T_GAP) e = 4'd0;
      else if (t < 2 * T_SYM + T_GAP) e = rom_s1[r];
      else e = 4'd0;
      if (leds !== e && bad < 0) bad = t;
      tick();
    end
    chk("show_leds_first_bad_cycle", bad, -1);
    chk("wait_entry", {25'd0, HEX4}, {25'd0, seg(3)});
    chk("wait_idx0", {25'd0, HEX3}, {25'd0, seg(0)});
  endtask

  task automatic start_game(input bit nv);
    jogar = 1'b1;
    repeat (5) tick();
    jogar = 1'b0;
    chk("config_state", {25'd0, HEX4}, {25'd0, seg(1)});
    chk("config_pronto", {31'd0, pronto}, 32'd0);
    chk("config_timeout", {31'd0, timeout}, 32'd0);
    chk("config_round", {18'd0, HEX1, HEX0}, {18'd0, seg(0), seg(1)});
    nivel = nv;
    confirma = 1'b1;
    tick();
    confirma = 1'b0;
    m_round = 1;
    m_idx = 1'b0;
    m_last = 4'd0;
    m_lvl = nv;
    show_check(1);
  endtask

  // One press in WAIT; the model decides ignore / advance / lose.
  task automatic press_step(input logic [3:0] v, input int hold);
    logic [3:0] exp_sym;
    bit ignored, hit;
    exp_sym = m_idx ? rom_s1[m_round] : rom_s0[m_round];
    ignored = (v == m_last);
    hit = (v == exp_sym);
    botoes = v;
    #1 chk("wait_echo", {28'd0, leds}, {28'd0, v});
    tick();
    if (ignored) begin
      chk("dup_ignored", {25'd0, HEX4}, {25'd0, seg(3)});
      for (int i = 1; i < hold; i++) tick();
      botoes = 4'd0;
      tick();
      chk("dup_still_wait", {25'd0, HEX4}, {25'd0, seg(3)});
      return;
    end
    chk("check_state", {25'd0, HEX4}, {25'd0, seg(4)});
    m_last = v;
    if (hold < 2) botoes = 4'd0;
    tick();
    if (!hit) begin
      botoes = 4'd0;
      chk("lose_state", {25'd0, HEX4}, {25'd0, seg(7)});
      chk("lose_pronto", {31'd0, pronto}, 32'd1);
      chk("lose_timeout", {31'd0, timeout}, 32'd0);
      return;
    end
    if (!m_idx) begin
      m_idx = 1'b1;
      chk("play_back_wait", {25'd0, HEX4}, {25'd0, seg(3)});
      chk("play_idx1", {25'd0, HEX3}, {25'd0, seg(1)});
      for (int i = 2; i < hold; i++) tick();
      botoes = 4'd0;
      tick();
      chk("held_counts_once", {25'd0, HEX4}, {25'd0, seg(3)});
    end else begin
      chk("next_state", {25'd0, HEX4}, {25'd0, seg(5)});
      botoes = 4'd0;
      tick();
      if (m_round == 16) begin
        chk("win_state", {25'd0, HEX4}, {25'd0, seg(6)});
        chk("win_pronto", {31'd0, pronto}, 32'd1);
        chk("win_timeout", {31'd0, timeout}, 32'd0);
        chk("win_round", {18'd0, HEX1, HEX0}, {18'd0, seg(1), seg(6)});
      end else begin
        m_round++;
        m_idx = 1'b0;
        m_last = 4'd0;
        show_check(m_round);
      end
    end
  endtask

  task automatic play_round();
    int r;
    r = m_round;
    press_step(rom_s0[r], int'($urandom_range(1, 8)));
    if ($urandom_range(0, 2) == 0) press_step(rom_s0[r], int'($urandom_range(1, 6)));
    press_step(rom_s1[r], int'($urandom_range(1, 8)));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rom_s0 = '{4'h1, 4'h4, 4'h4, 4'h4, 4'h1, 4'h4, 4'h8, 4'h1, 4'h4, 4'h2, 4'h1, 4'h4, 4'h8, 4'h4, 4'h8, 4'h1};
    rom_s1 = '{4'h8, 4'h2, 4'h1, 4'h8, 4'h4, 4'h2, 4'h1, 4'h8, 4'h2, 4'h4, 4'h4, 4'h1, 4'h4, 4'h8, 4'h1, 4'h4};
    reset = 1'b0;
    jogar = 1'b0;
    nivel = 1'b0;
    confirma = 1'b0;
    botoes = 4'd0;
    repeat (3) tick();
    idle_checks();
    reset = 1'b1;
    tick();
    idle_checks();

    // Round 1 with a held press and an ignored repeat, then the full game to WIN.
    start_game(1'b0);
    press_step(4'b0001, 10);
    press_step(4'b0001, 3);
    press_step(4'b1000, 2);
    for (int r = 2; r <= 16; r++) begin
      if (r == 3) begin
        jogar = 1'b1;
        confirma = 1'b1;
        tick();
        jogar = 1'b0;
        confirma = 1'b0;
        chk("jogar_ignored_in_wait", {25'd0, HEX4}, {25'd0, seg(3)});
      end
      play_round();
    end

    // Wrong symbol in round 2, then confirma ignored in LOSE.
    start_game(1'b0);
    play_round();
    press_step(4'b0001, 2);
    confirma = 1'b1;
    tick();
    confirma = 1'b0;
    chk("lose_holds", {25'd0, HEX4}, {25'd0, seg(7)});

    // Multi-hot press loses.
    start_game(1'b0);
    press_step(4'b0011, 1);

    // Level 1 timeout exactly 1500 cycles after WAIT entry.
    start_game(1'b1);
    repeat (1499) tick();
    chk("tout1_not_yet", {25'd0, HEX4}, {25'd0, seg(3)});
    tick();
    chk("tout1_state", {25'd0, HEX4}, {25'd0, seg(8)});
    chk("tout1_pronto", {31'd0, pronto}, 32'd1);
    chk("tout1_timeout", {31'd0, timeout}, 32'd1);
    chk("tout1_leds", {28'd0, leds}, 32'd0);
    jogar = 1'b1;
    tick();
    jogar = 1'b0;
    chk("tout_restart_state", {25'd0, HEX4}, {25'd0, seg(1)});
    chk("tout_restart_pronto", {31'd0, pronto}, 32'd0);
    chk("tout_restart_timeout", {31'd0, timeout}, 32'd0);

    // Level 0 timer restarts when WAIT is re-entered after a correct press.
    start_game(1'b0);
    repeat ($urandom_range(10, 500)) tick();
    press_step(rom_s0[1], 1);
    repeat (2998) tick();
    chk("tout0_not_yet", {25'd0, HEX4}, {25'd0, seg(3)});
    tick();
    chk("tout0_state", {25'd0, HEX4}, {25'd0, seg(8)});
    chk("tout0_timeout", {31'd0, timeout}, 32'd1);

    // Asynchronous reset in the middle of SHOW.
    jogar = 1'b1;
    tick();
    jogar = 1'b0;
    confirma = 1'b1;
    tick();
    confirma = 1'b0;
    repeat (20) tick();
    chk("mid_show_leds", {28'd0, leds}, {28'd0, rom_s0[1]});
    #1 reset = 1'b0;
    #1;
    chk("async_leds", {28'd0, leds}, 32'd0);
    chk("async_state", {25'd0, HEX4}, {25'd0, seg(0)});
    chk("async_round", {18'd0, HEX1, HEX0}, {18'd0, seg(0), seg(0)});
    chk("async_pronto", {31'd0, pronto}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    idle_checks();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
